count_monitor_display: RTL and testbench
========================================

// Module: count_monitor_display
// PURPOSE
//   Downstream consumer of the 4-bit ripple carry counter output q. Samples q every clk,
//   checks that consecutive samples step legally, and counts wrap-arounds (max->0).
//   Drives a 2-digit multiplexed, active-low 7-segment display:
//   digit0 = current count (hex), digit1 = wrap count (hex).
//   Sits between the counter and the board display pins; also gives the bench a self-check point.
// PARAMETERS
//   WIDTH       4  width of monitored count q; digit0 shows q_d[3:0]
//   WRAP_W      4  width of wrap_cnt; wraps modulo 2**WRAP_W
//   REFRESH_DIV 4  clk cycles each digit is held before scanning to the other (>=1)
// PORTS
//   clk         in   1        single clock, rising edge
//   reset       in   1        synchronous, active-low reset
//   q           in   WIDTH    count from upstream counter, sampled every rising edge
//   wrap_pulse  out  1        1-cycle pulse: legal wrap max->0 detected
//   restart     out  1        1-cycle pulse: jump to 0 from a value other than 0 or max (upstream reset)
//   step_err    out  1        sticky: illegal step seen
//   wrap_cnt    out  WRAP_W   number of wraps since reset
//   seg         out  7        segments {g,f,e,d,c,b,a}, active-low
//   an          out  2        digit enables, active-low; an[0]=digit0, an[1]=digit1
// BEHAVIOUR
//   Reset (reset==0 at a rising edge):
//     q_d=0, primed=0, wrap_cnt=0, wrap_pulse=0, restart=0, step_err=0,
//     scan state DIG0, div_cnt=0, an=2'b10, seg=7'b1000000 (hex 0).
//   Sampling:
//     Every non-reset edge: q_d<=q.
//     First edge after reset: only sets primed=1; no checks, no pulses.
//   Step classification (primed==1; q vs old q_d, registered at the same edge; result visible the next cycle):
//     q==q_d            -> hold, legal, no pulse
//     q==q_d+1, q_d!=max -> legal increment, no pulse
//     q_d==max, q==0    -> wrap: wrap_pulse=1, wrap_cnt<=wrap_cnt+1 (mod 2**WRAP_W, 15->0 wraps silently)
//     q==0, q_d not in {0,max} -> restart=1; wrap_cnt unchanged; no error
//     any other         -> step_err<=1 (sticky until reset); no pulse
//   wrap_pulse and restart are mutually exclusive and low in every unflagged cycle.
//   Scan FSM, states DIG0/DIG1:
//     div_cnt counts 0..REFRESH_DIV-1 in each state.
//     At REFRESH_DIV-1: toggle state, clear div_cnt.
//     DIG0: an=2'b10, seg=hex(q_d[3:0]).  DIG1: an=2'b01, seg=hex(wrap_cnt[3:0]).
//     an and seg are registered and change on the same edge; never both digits on.
//   Hex decode (active-low gfedcba):
//     0=1000000 1=1111001 2=0100100 3=0110000 4=0011001 5=0010010 6=0000010 7=1111000
//     8=0000000 9=0010000 A=0001000 b=0000011 C=1000110 d=0100001 E=0000110 F=0001110
//   Reset mid-operation: all state returns to reset values at that edge, including sticky step_err;
//     the next edge re-primes.
//   Display reflects q_d, so it lags the counter by one cycle.
// TESTING
//   1 Reset low 2 edges, then q=0 held -> all outputs at reset values; an=10, seg=1000000.
//   2 q steps 0..15 one per edge, then 0 -> exactly one wrap_pulse (cycle after 0 sampled),
//     wrap_cnt=1, step_err=0.
//   3 Count 0..9, then q=0 (upstream reset pulse) -> restart=1 for one cycle,
//     wrap_cnt unchanged, step_err=0.
//   4 q jumps 3->7 -> step_err=1 and stays 1 through later legal counting until reset low.
//   5 17 full wraps -> wrap_cnt=1 (mod 16);
//     with REFRESH_DIV=4, an alternates 10/01 every 4 cycles;
//     seg in DIG1 = 1111001.
//   6 Reset low mid-count (q=6) for 1 edge -> next cycle all outputs at reset values, step_err cleared;
//     first edge after reset generates no flags.

Source files
------------

// File: rtl/count_monitor_display.sv
// count_monitor_display: watches a free-running counter value, classifies each
// step (hold / increment / wrap / restart / error), counts wraps, and scans the
// live count and the wrap count onto a 2-digit active-low 7-segment display.
module count_monitor_display #(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned WRAP_W      = 4,
  parameter int unsigned REFRESH_DIV = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  q,
  output logic              wrap_pulse,
  output logic              restart,
  output logic              step_err,
  output logic [WRAP_W-1:0] wrap_cnt,
  output logic [6:0]        seg,
  output logic [1:0]        an
);

  localparam int unsigned     DIV_W    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
  localparam logic [WIDTH-1:0] Q_MAX    = '1;

  typedef enum logic {
    DIG0 = 1'b0,
    DIG1 = 1'b1
  } scan_state_t;

  logic [WIDTH-1:0]  q_d;
  logic              primed;
  logic              step_hold;
  logic              step_inc;
  logic              step_wrap;
  logic              step_restart;
  logic              step_bad;
  logic [WRAP_W-1:0] wrap_next;

  scan_state_t       state;
  scan_state_t       state_next;
  logic [DIV_W-1:0]  div_cnt;
  logic [DIV_W-1:0]  div_next;
  logic [1:0]        an_next;
  logic [6:0]        seg_next;

  // Active-low gfedcba pattern for one hex digit.
  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // Classify the incoming sample against the previous one; nothing is judged until primed.
  always_comb begin
    step_hold    = 1'b0;
    step_inc     = 1'b0;
    step_wrap    = 1'b0;
    step_restart = 1'b0;
    step_bad     = 1'b0;
    wrap_next    = wrap_cnt;
    if (primed) begin
      step_hold    = (q == q_d);
      step_inc     = (q_d != Q_MAX) && (q == WIDTH'(q_d + 1'b1));
      step_wrap    = (q_d == Q_MAX) && (q == '0);
      step_restart = (q == '0) && (q_d != '0) && (q_d != Q_MAX);
      step_bad     = !(step_hold || step_inc || step_wrap || step_restart);
    end
    if (step_wrap) begin
      wrap_next = WRAP_W'(wrap_cnt + 1'b1);
    end
  end

  // Sample register, step flags and wrap counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      q_d        <= '0;
      primed     <= 1'b0;
      wrap_pulse <= 1'b0;
      restart    <= 1'b0;
      step_err   <= 1'b0;
      wrap_cnt   <= '0;
    end else begin
      q_d        <= q;
      primed     <= 1'b1;
      wrap_pulse <= step_wrap;
      restart    <= step_restart;
      step_err   <= step_err | step_bad;
      wrap_cnt   <= wrap_next;
    end
  end

  // Scan next-state plus display drive; seg tracks the freshly sampled values so it
  // matches q_d and wrap_cnt in the same cycle.
  always_comb begin
    state_next = state;
    div_next   = DIV_W'(div_cnt + 1'b1);
    an_next    = 2'b10;
    seg_next   = hex7(4'(q));
    if (div_cnt == DIV_LAST) begin
      div_next   = '0;
      state_next = (state == DIG0) ? DIG1 : DIG0;
    end
    if (state_next == DIG1) begin
      an_next  = 2'b01;
      seg_next = hex7(4'(wrap_next));
    end
  end

  // Scan state register and registered display outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= DIG0;
      div_cnt <= '0;
      an      <= 2'b10;
      seg     <= 7'b1000000;
    end else begin
      state   <= state_next;
      div_cnt <= div_next;
      an      <= an_next;
      seg     <= seg_next;
    end
  end

endmodule

// File: tb/tb_count_monitor_display.sv
// Directed bench for count_monitor_display: step classification, wrap counting,
// sticky error, mid-run reset and display scanning.
module tb_count_monitor_display;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] q;
  logic       wrap_pulse;
  logic       restart;
  logic       step_err;
  logic [3:0] wrap_cnt;
  logic [6:0] seg;
  logic [1:0] an;

  int checks = 0;
  int errors = 0;
  int ecnt = 0;
  int wraps_seen = 0;

  count_monitor_display #(
    .WIDTH(4),
    .WRAP_W(4),
    .REFRESH_DIV(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .q(q),
    .wrap_pulse(wrap_pulse),
    .restart(restart),
    .step_err(step_err),
    .wrap_cnt(wrap_cnt),
    .seg(seg),
    .an(an)
  );

  always #5 clk = ~clk;

  // One clock edge; outputs sampled 1 time unit later, wrap pulses tallied.
  task automatic tick();
    @(posedge clk);
    #1;
    ecnt++;
    if (wrap_pulse === 1'b1) wraps_seen++;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    @(posedge clk);
    #1;
    ecnt = 0;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    q = 4'd0;
    @(posedge clk);
    @(posedge clk);
    #1;
    ecnt = 0;
    checks++; if (wrap_pulse !== 1'b0) begin errors++; $display("FAIL reset_wrap_pulse got %b want 0", wrap_pulse); end
    checks++; if (restart !== 1'b0) begin errors++; $display("FAIL reset_restart got %b want 0", restart); end
    checks++; if (step_err !== 1'b0) begin errors++; $display("FAIL reset_step_err got %b want 0", step_err); end
    checks++; if (wrap_cnt !== 4'd0) begin errors++; $display("FAIL reset_wrap_cnt got %0d want 0", wrap_cnt); end
    checks++; if (an !== 2'b10) begin errors++; $display("FAIL reset_an got %b want 10", an); end
    checks++; if (seg !== 7'b1000000) begin errors++; $display("FAIL reset_seg got %b want 1000000", seg); end
    reset = 1'b1;
  endtask

  task automatic test_wrap();
    wraps_seen = 0;
    q = 4'd0;
    tick();
    for (int v = 1; v <= 15; v++) begin
      q = 4'(v);
      tick();
    end
    checks++; if (wrap_pulse !== 1'b0) begin errors++; $display("FAIL wrap_pre_pulse got %b want 0", wrap_pulse); end
    q = 4'd0;
    tick();
    checks++; if (wrap_pulse !== 1'b1) begin errors++; $display("FAIL wrap_pulse got %b want 1", wrap_pulse); end
    checks++; if (restart !== 1'b0) begin errors++; $display("FAIL wrap_restart got %b want 0", restart); end
    checks++; if (wrap_cnt !== 4'd1) begin errors++; $display("FAIL wrap_cnt got %0d want 1", wrap_cnt); end
    tick();
    checks++; if (wrap_pulse !== 1'b0) begin errors++; $display("FAIL wrap_pulse_width got %b want 0", wrap_pulse); end
    checks++; if (wraps_seen !== 1) begin errors++; $display("FAIL wrap_pulse_count got %0d want 1", wraps_seen); end
    checks++; if (step_err !== 1'b0) begin errors++; $display("FAIL wrap_step_err got %b want 0", step_err); end
  endtask

  task automatic test_restart();
    apply_reset();
    for (int v = 0; v <= 9; v++) begin
      q = 4'(v);
      tick();
      if (ecnt == 3) begin
        checks++; if (an !== 2'b10) begin errors++; $display("FAIL scan_dig0_an got %b want 10", an); end
        checks++; if (seg !== 7'b0100100) begin errors++; $display("FAIL scan_dig0_seg got %b want 0100100", seg); end
      end
      if (ecnt == 4) begin
        checks++; if (an !== 2'b01) begin errors++; $display("FAIL scan_dig1_an got %b want 01", an); end
        checks++; if (seg !== 7'b1000000) begin errors++; $display("FAIL scan_dig1_seg got %b want 1000000", seg); end
      end
    end
    q = 4'd0;
    tick();
    checks++; if (restart !== 1'b1) begin errors++; $display("FAIL restart_pulse got %b want 1", restart); end
    checks++; if (wrap_pulse !== 1'b0) begin errors++; $display("FAIL restart_wrap_pulse got %b want 0", wrap_pulse); end
    checks++; if (wrap_cnt !== 4'd0) begin errors++; $display("FAIL restart_wrap_cnt got %0d want 0", wrap_cnt); end
    checks++; if (step_err !== 1'b0) begin errors++; $display("FAIL restart_step_err got %b want 0", step_err); end
    tick();
    checks++; if (restart !== 1'b0) begin errors++; $display("FAIL restart_width got %b want 0", restart); end
  endtask

  task automatic test_step_err();
    apply_reset();
    for (int v = 0; v <= 3; v++) begin
      q = 4'(v);
      tick();
    end
    checks++; if (step_err !== 1'b0) begin errors++; $display("FAIL err_before_jump got %b want 0", step_err); end
    q = 4'd7;
    tick();
    checks++; if (step_err !== 1'b1) begin errors++; $display("FAIL err_jump got %b want 1", step_err); end
    checks++; if (restart !== 1'b0 || wrap_pulse !== 1'b0) begin errors++; $display("FAIL err_pulses got %b%b want 00", restart, wrap_pulse); end
    q = 4'd8;
    tick();
    q = 4'd9;
    tick();
    checks++; if (step_err !== 1'b1) begin errors++; $display("FAIL err_sticky got %b want 1", step_err); end
    apply_reset();
    checks++; if (step_err !== 1'b0) begin errors++; $display("FAIL err_cleared got %b want 0", step_err); end
  endtask

  task automatic test_wraps_scan();
    logic [1:0] exp_an;
    logic [6:0] exp_seg;
    apply_reset();
    wraps_seen = 0;
    q = 4'd0;
    tick();
    repeat (17) begin
      for (int v = 1; v <= 15; v++) begin
        q = 4'(v);
        tick();
      end
      q = 4'd0;
      tick();
    end
    tick();
    checks++; if (wraps_seen !== 17) begin errors++; $display("FAIL wraps_pulses got %0d want 17", wraps_seen); end
    checks++; if (wrap_cnt !== 4'd1) begin errors++; $display("FAIL wraps_mod16 got %0d want 1", wrap_cnt); end
    checks++; if (step_err !== 1'b0) begin errors++; $display("FAIL wraps_step_err got %b want 0", step_err); end
    for (int i = 0; i < 16; i++) begin
      tick();
      exp_an  = (((ecnt / 4) % 2) == 0) ? 2'b10 : 2'b01;
      exp_seg = (exp_an == 2'b10) ? 7'b1000000 : 7'b1111001;
      checks++; if (an !== exp_an) begin errors++; $display("FAIL scan_an edge %0d got %b want %b", ecnt, an, exp_an); end
      checks++; if (seg !== exp_seg) begin errors++; $display("FAIL scan_seg edge %0d got %b want %b", ecnt, seg, exp_seg); end
    end
  endtask

  task automatic test_mid_reset();
    apply_reset();
    q = 4'd0; tick();
    q = 4'd1; tick();
    q = 4'd2; tick();
    q = 4'd3; tick();
    q = 4'd5; tick();
    q = 4'd6; tick();
    checks++; if (step_err !== 1'b1) begin errors++; $display("FAIL mid_err_set got %b want 1", step_err); end
    reset = 1'b0;
    tick();
    ecnt = 0;
    checks++; if (step_err !== 1'b0) begin errors++; $display("FAIL mid_step_err got %b want 0", step_err); end
    checks++; if (restart !== 1'b0 || wrap_pulse !== 1'b0) begin errors++; $display("FAIL mid_pulses got %b%b want 00", restart, wrap_pulse); end
    checks++; if (wrap_cnt !== 4'd0) begin errors++; $display("FAIL mid_wrap_cnt got %0d want 0", wrap_cnt); end
    checks++; if (an !== 2'b10 || seg !== 7'b1000000) begin errors++; $display("FAIL mid_display got %b %b want 10 1000000", an, seg); end
    reset = 1'b1;
    tick();
    checks++; if (step_err !== 1'b0 || restart !== 1'b0 || wrap_pulse !== 1'b0) begin
      errors++; $display("FAIL prime_flags got %b%b%b want 000", step_err, restart, wrap_pulse);
    end
    checks++; if (seg !== 7'b0000010) begin errors++; $display("FAIL prime_seg got %b want 0000010", seg); end
    q = 4'd7;
    tick();
    checks++; if (step_err !== 1'b0 || restart !== 1'b0 || wrap_pulse !== 1'b0) begin
      errors++; $display("FAIL after_prime_flags got %b%b%b want 000", step_err, restart, wrap_pulse);
    end
    checks++; if (an !== 2'b10 || seg !== 7'b1111000) begin errors++; $display("FAIL after_prime_display got %b %b want 10 1111000", an, seg); end
  endtask

  initial begin
    test_reset();
    test_wrap();
    test_restart();
    test_step_err();
    test_wraps_scan();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
